// File: rtl/hqc_uart_rx_pkg.sv
// Shared types and defaults for the HQC UART receive path.
// Receiver state encoding, default line settings and the bit-period helper.
package hqc_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD   = 115_200;

  // Integer division: the residual baud error is absorbed by mid-bit sampling.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/hqc_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs, with a selectable reset value
// so idle-high lines do not glitch low out of reset.
module hqc_sync2 #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments so both stages update from pre-edge values;
  // blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hqc_uart_rx.sv
// UART 8N1 receiver feeding a one-entry valid/ready buffer, with framing-error and overrun pulses.
// Define HQC_UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module hqc_uart_rx
  import hqc_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int unsigned BAUD         = DEFAULT_BAUD,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_cfg_check
      $fatal(1, "hqc_uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  logic rxs;

  hqc_sync2 #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync_rx (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rxs)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             byte_done;
  logic             frame_bad;
  logic             cnt_last;
`ifdef HQC_UART_RX_PARITY_EN
  logic             parity_ok_q, parity_ok_d;
`endif

  assign cnt_last = (cnt_q == CNT_LAST);

  // NOTE: every signal gets its default before the case so no path leaves one
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_bad = 1'b0;
`ifdef HQC_UART_RX_PARITY_EN
    parity_ok_d = parity_ok_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end

      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // Line back high at mid start bit means a glitch, not a frame.
          state_d   = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_last) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef HQC_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef HQC_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          cnt_d       = '0;
          parity_ok_d = ((^shift_q) == rxs);
          state_d     = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (!rxs) begin
            frame_bad = 1'b1;
            state_d   = BREAK;
          end else begin
            state_d = IDLE;
`ifdef HQC_UART_RX_PARITY_EN
            if (parity_ok_q) byte_done = 1'b1;
            else             frame_bad = 1'b1;
`else
            byte_done = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A held-low line stays here so it reports only one framing error.
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // One-entry output buffer: a held byte is never overwritten, a new one is dropped instead.
  always_comb begin
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = frame_bad;

    if (byte_done) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = shift_q;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef HQC_UART_RX_PARITY_EN
      parity_ok_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef HQC_UART_RX_PARITY_EN
      parity_ok_q <= parity_ok_d;
`endif
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/hqc_uart_rx.md
Name: hqc_uart_rx

Overview:
- Serial receive front end for the HQC decapsulation wrapper on the CW305.
- Takes the raw UART line driven by the Husky TX and synchronises it into the FPGA clock domain.
- Deserialises 8N1 frames, LSB first, and delivers each byte over a valid/ready stream to the wrapper's command/ciphertext loader.
- Reports framing errors and overrun so the host protocol layer can resynchronise.

Parameters:
- CLK_HZ, 50000000, frequency of clk in Hz.
- BAUD, 115200, line rate in bits per second.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division; 434 at defaults), clock cycles per bit. A value below 4 is an elaboration error.

Ports:
- clk  in  1  system clock, 50 MHz from the Husky.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx  in  1  raw UART line; idle high; asynchronous to clk.
- m_data  out  8  received byte.
- m_valid  out  1  m_data holds an unconsumed byte.
- m_ready  in  1  consumer accepts m_data this cycle.
- busy  out  1  a frame is in progress (state not IDLE).
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the buffer was full.

Behaviour:
- Reset: while rst_n is low, all of the following hold asynchronously:
  - m_valid=0, m_data=0x00, busy=0, frame_err=0, overrun=0.
  - Both synchroniser flops=1, state=IDLE, counters=0.
- Synchroniser: 2-flop; rxs is the second flop. No other logic samples rx directly.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2 (integer; 217 at defaults).
- IDLE:
  - rxs==0 → START, cnt=0.
- START:
  - When cnt==HALF-1, sample rxs.
  - rxs==0 → DATA, cnt=0, bit index=0.
  - rxs==1 → glitch; return to IDLE with no output and no error.
- DATA:
  - When cnt==CLKS_PER_BIT-1, shift rxs into the shift register MSB, shifting right (LSB first on the line).
  - After bit index 7 → STOP (or PARITY if enabled).
- STOP:
  - When cnt==CLKS_PER_BIT-1, sample rxs.
  - rxs==1 → byte complete; go to IDLE.
  - rxs==0 → frame_err pulse, byte discarded; go to BREAK.
- BREAK:
  - Wait for rxs==1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Output buffer (one entry):
  - On byte complete with m_valid==0, or with m_valid&&m_ready in the same cycle: load m_data and set m_valid=1 the next cycle.
  - On byte complete with m_valid&&!m_ready: overrun pulse; the held byte is kept unchanged and the new byte is dropped.
  - m_valid&&m_ready with no completion: m_valid=0 next cycle.
  - m_data is stable whenever m_valid=1.
- Latency: m_valid rises 2+HALF+9*CLKS_PER_BIT+1 cycles (4126 at defaults, ±1) after the rx falling edge of the start bit.
- Back-to-back frames: the next start bit is accepted from the first IDLE cycle after the stop sample. Receiver lag of half a stop bit is tolerated.
- Mid-frame reset: the frame is abandoned. After release the receiver is in IDLE; if rx is low at release, the remaining low bits are treated as a start bit.

Optional Feature:
- Macro: HQC_UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit.
  - On mismatch: frame_err pulses at the stop sample and the byte is discarded, even if the stop bit is good.
  - Latency becomes 2+HALF+10*CLKS_PER_BIT+1.
- Undefined: 8N1 only; no PARITY state exists.

Decomposition:
- Package hqc_uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - Default CLK_HZ and BAUD constants.
  - Function computing clks_per_bit(clk_hz, baud).
- Sub-module hqc_sync2: generic 2-flop synchroniser with a reset-value parameter (1 here). It is reused for other async inputs.

Test Plan:
- Reset release, rx held at 1 for 10000 cycles → m_valid, busy, frame_err and overrun all stay 0.
- Send 0xA5 at 115200 with m_ready=1 → m_data=0xA5, m_valid high for exactly 1 cycle, 4126±1 cycles after the start edge.
- Send 0x3C then 0xC3 back-to-back with m_ready=0 → m_data=0x3C held, one overrun pulse. Raising m_ready then yields 0x3C only.
- 100-cycle low glitch on an idle line → no m_valid, no frame_err, busy returns to 0 within 220 cycles.
- rx held low for 20 bit times → exactly one frame_err pulse, no m_valid. After rx goes high, 0x55 is received correctly.
- With HQC_UART_RX_PARITY_EN: 0x01 sent with parity bit 0 → frame_err pulses and no m_valid. Sent with parity bit 1 → m_data=0x01.
